pc_tx_arbiter: RTL and testbench
================================

Name: pc_tx_arbiter

Overview:
- Round-robin scheduler that shares one PC transmit framing channel between four package sources.
- Selects one requester, runs the req/ack/done handshake with the sink, and steers that source's byte lane onto a single byte stream.
- An inactivity watchdog aborts stalled packets so the channel cannot lock up.
- Sits between the package builders and the single-channel PC tx framer.

Parameters:
- U_DLY, 1, register assignment delay (simulation only).
- TO_W, 16, width of the watchdog counter.
- TIMEOUT_CYC, 16'd4000, idle cycles allowed inside a packet before abort.
- IFG_CYC, 4'd4, idle gap cycles enforced between consecutive packets.

Ports:
- clk_sys  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_src_en  input  4  per-source enable mask; 0 = source never granted.
- src_req  input  4  package request, held high until that source's ack.
- src_ack  output  4  one-hot grant, high for the whole transfer.
- src_done  input  4  one-cycle end-of-package pulse.
- src_en  input  4  per-source byte valid.
- src_data  input  32  byte lane n = src_data[n*8+:8].
- snk_req  output  1  request to framer.
- snk_ack  input  1  framer accept.
- snk_sel  output  2  index of the granted source (framer frame type).
- snk_en  output  1  byte valid to framer.
- snk_data  output  8  byte to framer.
- snk_done  output  1  end-of-package pulse to framer.
- err_timeout  output  1  one-cycle abort pulse.
- err_src  output  2  source index of the last abort.
- stat_pkg_cnt  output  64  per-source package counters (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE, last-grant pointer = 3, so source 0 has first priority after reset.
- Reset asserted mid-packet aborts immediately; no snk_done is emitted.
- IDLE -> ARB after one cycle.
- ARB:
  - Eligible vector = src_req & cfg_src_en.
  - Winner = first eligible index searching (last+1), (last+2), ... mod 4.
  - If any source is eligible: register snk_sel = winner, update last = winner, go GRANT.
  - Otherwise stay in ARB.
- GRANT:
  - snk_req = 1.
  - On snk_ack = 1: snk_req -> 0, src_ack[snk_sel] -> 1 (registered), go XFER.
  - src_req is not re-checked after ARB; requests are sticky by contract.
- XFER:
  - snk_en, snk_data and snk_done are registered copies of src_en[sel], src_data[sel*8+:8] and src_done[sel].
  - Latency is exactly 1 cycle, and done stays aligned with data.
  - On src_done[sel]: src_ack drops to 0 the next cycle, go GAP.
- Watchdog:
  - Counts cycles in GRANT and XFER; cleared on every src_en[sel] and on state entry.
  - When the count reaches TIMEOUT_CYC:
    - In XFER: one snk_done pulse is forced.
    - In GRANT: snk_req drops and no snk_done is sent.
    - In both cases: err_timeout pulses for 1 cycle, err_src = sel, src_ack -> 0, go GAP.
  - The counter saturates and does not wrap.
- GAP:
  - Holds IFG_CYC cycles with snk_en = 0, then goes to ARB.
  - If IFG_CYC = 0, GAP lasts exactly 1 cycle.
- Simultaneous src_done[sel] and timeout in the same cycle: treat as normal completion, no error.
- src_en or src_done from non-selected sources is ignored.
- cfg_src_en changes take effect at the next ARB only; the current packet is not affected.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: PC_TX_ARB_STAT_EN.
- Defined:
  - stat_pkg_cnt[n*16+:16] increments by 1 on each normal completion of source n.
  - Counters saturate at 16'hFFFF.
  - Aborted packets are not counted.
  - Cleared only by rst_n.
- Undefined: stat_pkg_cnt is tied to 64'd0 and no counter logic is generated.

Test Plan:
- Single source: cfg_src_en = 4'hF, src_req = 4'b0100, sink acks 2 cycles after snk_req, source sends bytes 8'hA1, 8'hA2, 8'hA3 then done.
  -> snk_sel = 2, src_ack = 4'b0100, snk_data = A1/A2/A3 one cycle after each src_en, snk_done one cycle after src_done, src_ack = 0 the next cycle.
- Fairness: src_req = 4'hF held and re-raised after each done.
  -> grant order 0, 1, 2, 3, 0; at least IFG_CYC = 4 idle cycles between packets.
- Mask: cfg_src_en = 4'b1010, src_req = 4'hF.
  -> grants alternate 1, 3, 1; sources 0 and 2 are never acked.
- Timeout: TIMEOUT_CYC = 16, source 1 granted, sends 1 byte then stalls.
  -> 16 cycles after that byte: forced snk_done, err_timeout pulse, err_src = 1, src_ack = 0, next grant goes to source 2 if it is requesting.
- Reset mid-XFER: rst_n low during byte 3 of a packet.
  -> all outputs 0 immediately, no snk_done; after release, source 0 is granted first.
- Statistics (PC_TX_ARB_STAT_EN defined): 3 normal packets on source 3 and 1 timed-out packet on source 3.
  -> stat_pkg_cnt[63:48] = 16'd3.

Source files
------------

// File: rtl/pc_tx_arbiter.sv
// Round-robin arbiter sharing one PC tx framing channel between four package sources.
// Optional per-source completion counters are built when PC_TX_ARB_STAT_EN is defined.
//
// state | meaning
// IDLE  | post-reset settle, moves to ARB after one cycle
// ARB   | pick next eligible source after the last grant
// GRANT | snk_req raised, waiting for framer accept
// XFER  | selected lane steered to the sink stream
// GAP   | inter-frame gap before the next arbitration
module pc_tx_arbiter #(
  parameter int              U_DLY       = 1,
  parameter int              TO_W        = 16,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 16'd4000,
  parameter logic [3:0]      IFG_CYC     = 4'd4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [3:0]  cfg_src_en,
  input  logic [3:0]  src_req,
  output logic [3:0]  src_ack,
  input  logic [3:0]  src_done,
  input  logic [3:0]  src_en,
  input  logic [31:0] src_data,
  output logic        snk_req,
  input  logic        snk_ack,
  output logic [1:0]  snk_sel,
  output logic        snk_en,
  output logic [7:0]  snk_data,
  output logic        snk_done,
  output logic        err_timeout,
  output logic [1:0]  err_src,
  output logic [63:0] stat_pkg_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    GRANT = 3'd2,
    XFER  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      last;
  logic [TO_W-1:0] wd;
  logic [3:0]      gap_cnt;

  logic [3:0] elig;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       any_elig;
  logic       sel_en;
  logic       sel_done;
  logic       wd_expire;
  logic [7:0] lane;

  // U_DLY only shapes simulation delays elsewhere; it has no effect on this netlist.
  if (U_DLY < 0) begin : g_u_dly_range
  end

  always_comb begin
    elig   = src_req & cfg_src_en;
    winner = last;
    idx    = '0;
    // Walk from farthest to nearest so the source right after last wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) winner = idx;
    end
  end

  assign any_elig  = |elig;
  assign sel_en    = src_en[snk_sel];
  assign sel_done  = src_done[snk_sel];
  assign lane      = src_data[{snk_sel, 3'b000} +: 8];
  assign wd_expire = (wd <= TO_W'(1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 2'd3;
      wd          <= '0;
      gap_cnt     <= '0;
      src_ack     <= '0;
      snk_req     <= 1'b0;
      snk_sel     <= '0;
      snk_en      <= 1'b0;
      snk_data    <= '0;
      snk_done    <= 1'b0;
      err_timeout <= 1'b0;
      err_src     <= '0;
    end else begin
      snk_en      <= 1'b0;
      snk_done    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (any_elig) begin
            snk_sel <= winner;
            last    <= winner;
            snk_req <= 1'b1;
            wd      <= TIMEOUT_CYC;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (snk_ack) begin
            snk_req <= 1'b0;
            src_ack <= 4'b0001 << snk_sel;
            wd      <= TIMEOUT_CYC;
            state   <= XFER;
          end else if (sel_en) begin
            wd <= TIMEOUT_CYC;
          end else if (wd_expire) begin
            snk_req     <= 1'b0;
            err_timeout <= 1'b1;
            err_src     <= snk_sel;
            gap_cnt     <= IFG_CYC;
            state       <= GAP;
          end else begin
            wd <= wd - TO_W'(1);
          end
        end
        XFER: begin
          snk_en   <= sel_en;
          snk_data <= lane;
          snk_done <= sel_done;
          // A done coinciding with expiry is a normal completion.
          if (sel_done) begin
            src_ack <= '0;
            gap_cnt <= IFG_CYC;
            state   <= GAP;
          end else if (sel_en) begin
            wd <= TIMEOUT_CYC;
          end else if (wd_expire) begin
            snk_done    <= 1'b1;
            err_timeout <= 1'b1;
            err_src     <= snk_sel;
            src_ack     <= '0;
            gap_cnt     <= IFG_CYC;
            state       <= GAP;
          end else begin
            wd <= wd - TO_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1) state <= ARB;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          snk_req <= 1'b0;
          src_ack <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef PC_TX_ARB_STAT_EN
  logic [3:0][15:0] stat_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (state == XFER && sel_done && stat_cnt[snk_sel] != 16'hFFFF) begin
      stat_cnt[snk_sel] <= stat_cnt[snk_sel] + 16'd1;
    end
  end

  assign stat_pkg_cnt = stat_cnt;
`else
  assign stat_pkg_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_pc_tx_arbiter.sv
// Bench for pc_tx_arbiter: directed scenarios with randomized bytes, gaps and requests,
// checked against a round-robin / byte-queue reference kept in the bench.
module tb_pc_tx_arbiter;
  localparam int T   = 16;
  localparam int IFG = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [3:0]  cfg_src_en = '0;
  logic [3:0]  src_req    = '0;
  logic [3:0]  src_ack;
  logic [3:0]  src_done   = '0;
  logic [3:0]  src_en     = '0;
  logic [31:0] src_data   = '0;
  logic        snk_req;
  logic        snk_ack    = 1'b0;
  logic [1:0]  snk_sel;
  logic        snk_en;
  logic [7:0]  snk_data;
  logic        snk_done;
  logic        err_timeout;
  logic [1:0]  err_src;
  logic [63:0] stat_pkg_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_m = 3;
  int done_cyc = -1;
  int cnt_m[4] = '{0, 0, 0, 0};

  pc_tx_arbiter #(.TIMEOUT_CYC(16'd16), .IFG_CYC(4'd4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_src_en(cfg_src_en),
    .src_req(src_req), .src_ack(src_ack), .src_done(src_done),
    .src_en(src_en), .src_data(src_data), .snk_req(snk_req),
    .snk_ack(snk_ack), .snk_sel(snk_sel), .snk_en(snk_en),
    .snk_data(snk_data), .snk_done(snk_done), .err_timeout(err_timeout),
    .err_src(err_src), .stat_pkg_cnt(stat_pkg_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stat_exp();
`ifdef PC_TX_ARB_STAT_EN
    return {16'(cnt_m[3]), 16'(cnt_m[2]), 16'(cnt_m[1]), 16'(cnt_m[0])};
`else
    return 64'd0;
`endif
  endfunction

  function automatic int rr_pick(input logic [3:0] e, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (e[i]) return i;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  // Random activity on every lane except the selected one.
  task automatic drive_idle(input int sel);
    logic [3:0] m;
    m        = ~(4'b0001 << sel);
    src_en   = 4'($urandom) & m;
    src_done = 4'($urandom) & m;
    src_data = $urandom;
  endtask

  // mode 0: normal packet, 1: one byte then stall to timeout, 2: reset during byte 3
  task automatic run_pkt(input int n_in, input int mode, input bit fixed,
                         input int ack_dly, input bit rearm, input bit chg_cfg);
    int exp_sel;
    int w;
    int n;
    logic [3:0] oh;
    logic [7:0] b;
    bit comb;
    bit lastb;
    n = (mode == 1) ? 1 : n_in;
    src_en = '0;
    src_done = '0;
    exp_sel = rr_pick(src_req & cfg_src_en, last_m);
    w = 0;
    while (snk_req !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    chk("req_seen", snk_req, 1);
    chk("grant_sel", snk_sel, exp_sel[1:0]);
    chk("ack_idle", src_ack, 0);
    if (done_cyc >= 0) chk("ifg_gap", ((cyc - done_cyc - 1) >= IFG) ? 1 : 0, 1);
    last_m = exp_sel;
    oh = 4'b0001 << exp_sel;
    repeat (ack_dly) begin
      step();
      chk("req_hold", snk_req, 1);
    end
    snk_ack = 1'b1;
    step();
    snk_ack = 1'b0;
    chk("ack_onehot", src_ack, oh);
    chk("req_drop", snk_req, 0);
    if (chg_cfg) cfg_src_en = 4'($urandom_range(1, 15));
    comb = (mode == 0) && !fixed && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n; i++) begin
      if (!fixed && mode == 0) begin
        repeat ($urandom_range(0, 2)) begin
          drive_idle(exp_sel);
          step();
          chk("idle_en", snk_en, 0);
        end
      end
      b = fixed ? (8'hA1 + 8'(i)) : 8'($urandom);
      lastb = comb && (i == n - 1);
      drive_idle(exp_sel);
      src_en[exp_sel] = 1'b1;
      src_data[exp_sel*8 +: 8] = b;
      if (lastb) src_done[exp_sel] = 1'b1;
      if (mode == 2 && i == 2) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outs", {snk_req, src_ack, snk_sel, snk_en, snk_data, snk_done, err_timeout, err_src}, 0);
        chk("rst_stat", stat_pkg_cnt, 0);
        src_en = '0;
        src_done = '0;
        step();
        chk("rst_no_done", snk_done, 0);
        step();
        rst_n = 1'b1;
        last_m = 3;
        cnt_m = '{0, 0, 0, 0};
        done_cyc = -1;
        return;
      end
      step();
      chk("byte_en", snk_en, 1);
      chk("byte_data", snk_data, b);
      chk("byte_done", snk_done, lastb);
      chk("byte_ack", src_ack, lastb ? 4'b0000 : oh);
    end
    if (mode == 0) begin
      if (!comb) begin
        drive_idle(exp_sel);
        src_done[exp_sel] = 1'b1;
        step();
        chk("done", snk_done, 1);
        chk("done_en", snk_en, 0);
        chk("ack_drop", src_ack, 0);
      end
      chk("no_err", err_timeout, 0);
      cnt_m[exp_sel]++;
      done_cyc = cyc;
    end else begin
      for (int k = 1; k <= T; k++) begin
        drive_idle(exp_sel);
        step();
        if (k < T) begin
          chk("wd_quiet", {snk_done, err_timeout}, 0);
        end else begin
          chk("to_done", snk_done, 1);
          chk("to_err", err_timeout, 1);
          chk("to_src", err_src, exp_sel[1:0]);
          chk("to_ack", src_ack, 0);
          chk("to_en", snk_en, 0);
        end
      end
      done_cyc = cyc;
    end
    src_en = '0;
    src_done = '0;
    src_req[exp_sel] = rearm;
    if (mode == 1) begin
      step();
      chk("err_pulse", err_timeout, 0);
    end
    chk("stat", stat_pkg_cnt, stat_exp());
  endtask

  initial begin
    repeat (3) step();
    chk("rst_req", snk_req, 0);
    chk("rst_ack", src_ack, 0);
    chk("rst_sel", snk_sel, 0);
    chk("rst_sink", {snk_en, snk_data, snk_done}, 0);
    chk("rst_err", {err_timeout, err_src}, 0);
    chk("rst_stat0", stat_pkg_cnt, 0);
    rst_n = 1'b1;

    // fairness: all request, expect 0,1,2,3,0
    cfg_src_en = 4'hF;
    src_req = 4'hF;
    for (int p = 0; p < 5; p++) run_pkt(3, 0, 0, $urandom_range(0, 3), 1, 0);

    // single source with fixed bytes
    src_req = 4'b0100;
    run_pkt(3, 0, 1, 2, 0, 0);

    // mask: only sources 1 and 3
    cfg_src_en = 4'b1010;
    src_req = 4'hF;
    for (int p = 0; p < 3; p++) run_pkt(2, 0, 0, $urandom_range(0, 3), 1, 0);

    // timeout on source 1, then source 2 follows
    cfg_src_en = 4'hF;
    src_req = 4'b0110;
    last_m = last_m;
    run_pkt(1, 1, 0, 1, 0, 0);
    run_pkt(2, 0, 0, 1, 0, 0);

    // randomized requests, lengths and mid-packet mask changes
    for (int p = 0; p < 8; p++) begin
      do src_req = 4'($urandom); while ((src_req & cfg_src_en) == 4'b0000);
      run_pkt($urandom_range(1, 4), 0, 0, $urandom_range(0, 3), 0, $urandom_range(0, 1) == 1);
    end

    // reset mid-transfer, then source 0 first
    cfg_src_en = 4'hF;
    src_req = 4'hF;
    run_pkt(4, 2, 0, 1, 1, 0);
    src_req = 4'hF;
    run_pkt(2, 0, 0, 1, 1, 0);

    // three completions and one abort on source 3
    src_req = 4'b1000;
    for (int p = 0; p < 3; p++) run_pkt(2, 0, 0, 1, 1, 0);
    run_pkt(1, 1, 0, 1, 0, 0);
`ifdef PC_TX_ARB_STAT_EN
    chk("stat_src3", stat_pkg_cnt[63:48], 16'd3);
`else
    chk("stat_src3", stat_pkg_cnt[63:48], 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
